// File: rtl/ccip_c1_tx_shaper_pkg.sv
// Shared CCI-P c1 TX definitions for the NIC transmit path.
// Contents:
//   t_ccip_clLen / t_ccip_c1_req   - request length and type encodings
//   t_ccip_c1_ReqMemHdr            - c1 write request header
//   t_c1_beat                      - one stored beat (header + cache line)
//   t_if_ccip_c1_Tx                - c1 TX channel word (valid + beat)
//   ShaperState                    - shaper FSM states
//   cl_len_beats()                 - number of beats a request occupies
package ccip_c1_tx_shaper_pkg;

  localparam int CCIP_CLDATA_WIDTH = 512;
  localparam int CCIP_CLADDR_WIDTH = 42;
  localparam int CCIP_MDATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'd0,
    eCL_LEN_2 = 2'd1,
    eCL_LEN_3 = 2'd2,
    eCL_LEN_4 = 2'd3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef struct packed {
    logic [1:0]                   vc_sel;
    logic                         sop;
    t_ccip_clLen                  cl_len;
    t_ccip_c1_req                 req_type;
    logic [CCIP_CLADDR_WIDTH-1:0] address;
    logic [CCIP_MDATA_WIDTH-1:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr           hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
  } t_c1_beat;

  typedef struct packed {
    logic                         valid;
    t_ccip_c1_ReqMemHdr           hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
  } t_if_ccip_c1_Tx;

  typedef enum logic {ShIdle, ShBurst} ShaperState;

  // eCL_LEN_3 is not a legal CCI-P length; it is treated as a 4-beat request
  // so that a malformed header can never leave the ring mid-request.
  function automatic logic [2:0] cl_len_beats(input t_ccip_clLen cl_len);
    case (cl_len)
      eCL_LEN_1: return 3'd1;
      eCL_LEN_2: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ccip_c1_tx_shaper_if.sv
// Bus bundle around the c1 TX shaper.
//   in_c1            write beats from the transmitter
//   in_ready         shaper can accept more beats
//   sRx_c1TxAlmFull  platform c1 almost-full
//   sTx_c1           beats released to CCI-P c1
// master: the environment (transmitter + platform); slave: the shaper.
interface ccip_c1_tx_shaper_if;
  import ccip_c1_tx_shaper_pkg::*;

  t_if_ccip_c1_Tx in_c1;
  logic           in_ready;
  logic           sRx_c1TxAlmFull;
  t_if_ccip_c1_Tx sTx_c1;

  modport master (output in_c1, input in_ready, output sRx_c1TxAlmFull, input sTx_c1);
  modport slave  (input in_c1, output in_ready, input sRx_c1TxAlmFull, output sTx_c1);

endinterface

// File: rtl/ccip_c1_tx_shaper_ring.sv
// Beat ring for the c1 TX shaper: 2^LDEPTH entries of header + cache line,
// held in an inferred RAM with a registered read port.
// Ports:
//   clk, reset   clock, synchronous active-high reset (empties the ring)
//   push         write push_beat at the write pointer (caller ensures !full)
//   push_beat    beat to store
//   pop          advance the read pointer (caller ensures !empty)
//   head         oldest stored beat, valid whenever !empty
//   occupancy    stored beats, from registered pointers
//   full, empty  ring status, from registered pointers
module ccip_c1_tx_shaper_ring
  import ccip_c1_tx_shaper_pkg::*;
#(
  parameter int LDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  t_c1_beat        push_beat,
  input  logic            pop,
  output t_c1_beat        head,
  output logic [LDEPTH:0] occupancy,
  output logic            full,
  output logic            empty
);

  localparam int Depth = 1 << LDEPTH;

  t_c1_beat        mem [Depth];
  t_c1_beat        head_reg;
  logic [LDEPTH:0] wr_ptr_reg;
  logic [LDEPTH:0] rd_ptr_reg;
  logic [LDEPTH:0] rd_ptr_next;

  // The read address is the pointer value for the next cycle, so the head
  // register already shows the new oldest entry right after a pop.
  assign rd_ptr_next = pop ? rd_ptr_reg + (LDEPTH+1)'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (LDEPTH+1)'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[LDEPTH-1:0]] <= push_beat;
    end
  end

  // A beat written to the slot being read this cycle (ring empty, or the
  // last entry being popped) must be forwarded, or the head would be stale.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr_reg[LDEPTH-1:0] == rd_ptr_next[LDEPTH-1:0])) begin
      head_reg <= push_beat;
    end else begin
      head_reg <= mem[rd_ptr_next[LDEPTH-1:0]];
    end
  end

  assign head      = head_reg;
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[LDEPTH] != rd_ptr_reg[LDEPTH]) &&
                     (wr_ptr_reg[LDEPTH-1:0] == rd_ptr_reg[LDEPTH-1:0]);

endmodule

// File: rtl/ccip_c1_tx_shaper.sv
// CCI-P c1 TX shaper: buffers write beats and releases whole requests to the
// platform only while c1 almost-full is low. Multi-line requests leave as
// back-to-back beats once started.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          slave side of ccip_c1_tx_shaper_if (in_c1, in_ready,
//                sRx_c1TxAlmFull, sTx_c1)
//   occupancy    stored beats
//   drop_cnt     beats dropped on a full ring (saturating)
//   error        sticky: overflow drop or orphan non-sop head beat
module ccip_c1_tx_shaper
  import ccip_c1_tx_shaper_pkg::*;
#(
  parameter int NIC_ID       = 0,
  parameter int LDEPTH       = 4,
  parameter int READY_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  ccip_c1_tx_shaper_if.slave       bus,
  output logic [LDEPTH:0]          occupancy,
  output logic [31:0]              drop_cnt,
  output logic                     error
);

  localparam logic [LDEPTH:0] DepthCount  = (LDEPTH+1)'(1 << LDEPTH);
  localparam logic [LDEPTH:0] MarginCount = (LDEPTH+1)'(READY_MARGIN);

  // NIC_ID only tags traces; negative ids and a margin larger than the ring
  // are meaningless configurations and select no extra logic.
  if (NIC_ID < 0 || READY_MARGIN > (1 << LDEPTH)) begin : g_bad_params
  end

  ShaperState      state_reg;
  logic [1:0]      beats_left_reg;
  t_if_ccip_c1_Tx  tx_reg;
  logic [31:0]     drop_cnt_reg;
  logic            error_reg;

  logic            ring_full;
  logic            ring_empty;
  logic            push;
  logic            pop;
  logic            discard;
  t_c1_beat        head;
  t_c1_beat        push_beat;
  logic [2:0]      need;
  logic [LDEPTH:0] free_cnt;

  assign push           = bus.in_c1.valid && !ring_full;
  assign push_beat.hdr  = bus.in_c1.hdr;
  assign push_beat.data = bus.in_c1.data;

  ccip_c1_tx_shaper_ring #(
    .LDEPTH (LDEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy),
    .full      (ring_full),
    .empty     (ring_empty)
  );

  assign need = cl_len_beats(head.hdr.cl_len);

  // Pop decision. In Burst the remaining beats are known to be stored (the
  // start check required the whole request), so no status is consulted.
  always_comb begin
    pop     = 1'b0;
    discard = 1'b0;
    case (state_reg)
      ShIdle: begin
        if (!ring_empty) begin
          if (!head.hdr.sop) begin
            pop     = 1'b1;
            discard = 1'b1;
          end else if (occupancy >= (LDEPTH+1)'(need) && !bus.sRx_c1TxAlmFull) begin
            pop = 1'b1;
          end
        end
      end
      ShBurst: begin
        pop = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ShIdle;
      beats_left_reg <= 2'd0;
      tx_reg         <= '0;
      drop_cnt_reg   <= 32'd0;
      error_reg      <= 1'b0;
    end else begin
      tx_reg.valid <= pop && !discard;
      if (pop && !discard) begin
        tx_reg.hdr  <= head.hdr;
        tx_reg.data <= head.data;
      end

      // Fullness comes from start-of-cycle pointers, so a pop in the same
      // cycle does not rescue the incoming beat.
      if (bus.in_c1.valid && ring_full) begin
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
        error_reg <= 1'b1;
      end
      if (discard) begin
        error_reg <= 1'b1;
      end

      case (state_reg)
        ShIdle: begin
          if (pop && !discard) begin
            beats_left_reg <= 2'(need - 3'd1);
            if (need > 3'd1) begin
              state_reg <= ShBurst;
            end
          end
        end
        ShBurst: begin
          beats_left_reg <= beats_left_reg - 2'd1;
          if (beats_left_reg == 2'd1) begin
            state_reg <= ShIdle;
          end
        end
      endcase
    end
  end

  assign free_cnt     = DepthCount - occupancy;
  assign bus.in_ready = (free_cnt >= MarginCount);
  assign bus.sTx_c1   = tx_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_ccip_c1_tx_shaper.sv
// Self-checking bench for ccip_c1_tx_shaper. A queue-based reference model
// releases whole requests from a FIFO of stored beats and is advanced once
// per clock edge with the inputs the DUT saw at that edge.
module tb_ccip_c1_tx_shaper;
  import ccip_c1_tx_shaper_pkg::*;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccip_c1_tx_shaper_if bus();
  logic [4:0]  occupancy;
  logic [31:0] drop_cnt;
  logic        error;

  ccip_c1_tx_shaper #(.NIC_ID(0), .LDEPTH(4), .READY_MARGIN(MARGIN)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt),
    .error     (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  t_c1_beat           m_q[$];
  int                 m_rem;
  bit                 exp_valid;
  t_ccip_c1_ReqMemHdr exp_hdr;
  logic [511:0]       exp_data;
  bit                 exp_data_known;
  int unsigned        m_drops;
  bit                 m_err;

  function automatic int beats_for(input t_ccip_clLen l);
    if (l == eCL_LEN_1) return 1;
    if (l == eCL_LEN_2) return 2;
    return 4;
  endfunction

  function automatic t_c1_beat make_beat(input logic sop, input t_ccip_clLen len);
    t_c1_beat b;
    b.hdr.vc_sel   = 2'($urandom);
    b.hdr.sop      = sop;
    b.hdr.cl_len   = len;
    b.hdr.req_type = eREQ_WRLINE_I;
    b.hdr.address  = {10'($urandom), 32'($urandom)};
    b.hdr.mdata    = 16'($urandom);
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic drive(input t_c1_beat b);
    bus.in_c1.valid = 1'b1;
    bus.in_c1.hdr   = b.hdr;
    bus.in_c1.data  = b.data;
  endtask

  task automatic idle();
    bus.in_c1.valid = 1'b0;
  endtask

  // One clock edge of the reference: decisions use start-of-cycle contents.
  task automatic model_step();
    int n0;
    int need;
    t_c1_beat b;
    if (rst) begin
      m_q.delete();
      m_rem = 0; exp_valid = 0; exp_hdr = '0; exp_data_known = 0;
      m_drops = 0; m_err = 0;
      return;
    end
    n0 = m_q.size();
    exp_valid = 0;
    if (m_rem > 0) begin
      b = m_q.pop_front();
      exp_valid = 1; exp_hdr = b.hdr; exp_data = b.data; exp_data_known = 1;
      m_rem--;
    end else if (n0 > 0) begin
      if (!m_q[0].hdr.sop) begin
        void'(m_q.pop_front());
        m_err = 1;
      end else begin
        need = beats_for(m_q[0].hdr.cl_len);
        if (n0 >= need && !bus.sRx_c1TxAlmFull) begin
          b = m_q.pop_front();
          exp_valid = 1; exp_hdr = b.hdr; exp_data = b.data; exp_data_known = 1;
          m_rem = need - 1;
        end
      end
    end
    if (bus.in_c1.valid) begin
      if (n0 >= DEPTH) begin
        if (m_drops != 32'hFFFF_FFFF) m_drops++;
        m_err = 1;
      end else begin
        b.hdr = bus.in_c1.hdr; b.data = bus.in_c1.data;
        m_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); bus.sRx_c1TxAlmFull = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_c1 = '0; bus.sRx_c1TxAlmFull = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (bus.sTx_c1.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", bus.sTx_c1.valid); end
    n_cmp++; if (bus.sTx_c1.hdr !== exp_hdr) begin n_bad++; $display("FAIL reset_hdr got=%h exp=%h", bus.sTx_c1.hdr, exp_hdr); end
    n_cmp++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0b exp=1", bus.in_ready); end
    n_cmp++; if (drop_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%0b exp=0", error); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    t_c1_beat b;
    int lat = 0;
    do_reset();
    b = make_beat(1'b1, eCL_LEN_1);
    drive(b); tick(); idle();
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL single_valid cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
      if (bus.sTx_c1.valid === 1'b1 && lat == 0) lat = c;
      if (c < 5) tick();
    end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL single_latency got=%0d exp=2", lat); end
    n_cmp++; if (bus.sTx_c1.hdr !== b.hdr) begin n_bad++; $display("FAIL single_hdr got=%h exp=%h", bus.sTx_c1.hdr, b.hdr); end
    n_cmp++; if (bus.sTx_c1.data !== b.data) begin n_bad++; $display("FAIL single_data got=%h exp=%h", bus.sTx_c1.data, b.data); end
    $display("test_single: latency=%0d", lat);
  endtask

  task automatic test_burst4();
    t_c1_beat b[4];
    int k = 0, first = -1, last = -1;
    do_reset();
    for (int i = 0; i < 4; i++) b[i] = make_beat(i == 0, eCL_LEN_4);
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(b[c]); else idle();
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL burst_valid cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
      if (bus.sTx_c1.valid === 1'b1 && k < 4) begin
        n_cmp++; if (bus.sTx_c1.hdr !== b[k].hdr || bus.sTx_c1.data !== b[k].data) begin n_bad++; $display("FAIL burst_beat k=%0d got=%h exp=%h", k, bus.sTx_c1.hdr, b[k].hdr); end
        n_cmp++; if (bus.sTx_c1.hdr.sop !== (k == 0)) begin n_bad++; $display("FAIL burst_sop k=%0d got=%0b exp=%0b", k, bus.sTx_c1.hdr.sop, k == 0); end
        if (first < 0) first = c;
        last = c; k++;
      end
    end
    n_cmp++; if (k != 4 || last - first != 3) begin n_bad++; $display("FAIL burst_shape beats=%0d span=%0d exp beats=4 span=3", k, last - first); end
    $display("test_burst4: beats=%0d first_cyc=%0d", k, first);
  endtask

  task automatic test_almfull();
    t_c1_beat b[4];
    int k = 0, first = -1, last = -1;
    do_reset();
    bus.sRx_c1TxAlmFull = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive(make_beat(1'b1, eCL_LEN_1)); else idle();
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL almfull_hold cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
    end
    n_cmp++; if (occupancy !== 5'd3) begin n_bad++; $display("FAIL almfull_occ got=%0d exp=3", occupancy); end
    bus.sRx_c1TxAlmFull = 1'b0;
    tick();
    n_cmp++; if (bus.sTx_c1.valid !== 1'b1) begin n_bad++; $display("FAIL almfull_resume got=%0b exp=1", bus.sTx_c1.valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL almfull_drain cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
    end
    // flag rises while the burst is in flight: the rest must not stall
    for (int i = 0; i < 4; i++) b[i] = make_beat(i == 0, eCL_LEN_4);
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(b[c]); else idle();
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL midburst_valid cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
      if (bus.sTx_c1.valid === 1'b1 && k < 4) begin
        n_cmp++; if (bus.sTx_c1.hdr !== b[k].hdr) begin n_bad++; $display("FAIL midburst_hdr k=%0d got=%h exp=%h", k, bus.sTx_c1.hdr, b[k].hdr); end
        if (first < 0) first = c;
        last = c; k++;
        bus.sRx_c1TxAlmFull = 1'b1;
      end
    end
    n_cmp++; if (k != 4 || last - first != 3) begin n_bad++; $display("FAIL midburst_shape beats=%0d span=%0d exp beats=4 span=3", k, last - first); end
    bus.sRx_c1TxAlmFull = 1'b0;
    $display("test_almfull: burst beats=%0d", k);
  endtask

  task automatic test_overflow();
    t_c1_beat sent[18];
    int k = 0;
    do_reset();
    bus.sRx_c1TxAlmFull = 1'b1;
    for (int c = 0; c < 18; c++) begin
      sent[c] = make_beat(1'b1, eCL_LEN_1);
      drive(sent[c]); tick();
      n_cmp++; if (occupancy !== 5'(m_q.size())) begin n_bad++; $display("FAIL ovf_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_q.size()); end
      n_cmp++; if (bus.in_ready !== ((DEPTH - m_q.size()) >= MARGIN)) begin n_bad++; $display("FAIL ovf_ready cyc=%0d got=%0b exp=%0b", c, bus.in_ready, (DEPTH - m_q.size()) >= MARGIN); end
      n_cmp++; if (drop_cnt !== m_drops) begin n_bad++; $display("FAIL ovf_drop cyc=%0d got=%0d exp=%0d", c, drop_cnt, m_drops); end
    end
    idle();
    n_cmp++; if (occupancy !== 5'd16) begin n_bad++; $display("FAIL ovf_final_occ got=%0d exp=16", occupancy); end
    n_cmp++; if (drop_cnt !== 32'd2) begin n_bad++; $display("FAIL ovf_final_drop got=%0d exp=2", drop_cnt); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ovf_error got=%0b exp=1", error); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_full got=%0b exp=0", bus.in_ready); end
    bus.sRx_c1TxAlmFull = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.sTx_c1.valid === 1'b1) begin
        n_cmp++; if (k >= 16 || bus.sTx_c1.hdr !== sent[k].hdr) begin n_bad++; $display("FAIL ovf_drain_order k=%0d got=%h", k, bus.sTx_c1.hdr); end
        k++;
      end
    end
    n_cmp++; if (k != 16) begin n_bad++; $display("FAIL ovf_drain_count got=%0d exp=16", k); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ovf_error_sticky got=%0b exp=1", error); end
    $display("test_overflow: drained=%0d drops=%0d", k, drop_cnt);
  endtask

  task automatic test_sop_error();
    t_c1_beat bad, good;
    int k = 0;
    do_reset();
    bad  = make_beat(1'b0, eCL_LEN_1);
    good = make_beat(1'b1, eCL_LEN_1);
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(bad); else if (c == 1) drive(good); else idle();
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL soperr_valid cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
      if (bus.sTx_c1.valid === 1'b1) begin
        n_cmp++; if (bus.sTx_c1.hdr !== good.hdr) begin n_bad++; $display("FAIL soperr_hdr got=%h exp=%h", bus.sTx_c1.hdr, good.hdr); end
        k++;
      end
    end
    n_cmp++; if (k != 1) begin n_bad++; $display("FAIL soperr_count got=%0d exp=1", k); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL soperr_error got=%0b exp=1", error); end
    $display("test_sop_error: emitted=%0d", k);
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 0;
    do_reset();
    drive(make_beat(1'b0, eCL_LEN_1)); tick();
    for (int i = 0; i < 4; i++) begin drive(make_beat(i == 0, eCL_LEN_4)); tick(); end
    idle();
    for (int c = 0; c < 10 && !hit; c++) begin
      if (bus.sTx_c1.valid === 1'b1) hit = 1; else tick();
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_no_burst got=0 exp=1 within 10 cycles"); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_error got=%0b exp=1", error); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bus.sTx_c1.valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%0b exp=0", bus.sTx_c1.valid); end
    n_cmp++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (drop_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_drop got=%0d exp=0", drop_cnt); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rstmid_error got=%0b exp=0", error); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.sTx_c1.valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_abandon cyc=%0d got=%0b exp=0", c, bus.sTx_c1.valid); end
    end
    $display("test_reset_mid_burst: done");
  endtask

  task automatic test_random();
    t_c1_beat stream[$];
    t_ccip_clLen len;
    int n, si = 0, outs = 0;
    do_reset();
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 19) == 0) stream.push_back(make_beat(1'b0, eCL_LEN_1));
      len = t_ccip_clLen'($urandom_range(0, 3));
      n = beats_for(len);
      for (int i = 0; i < n; i++) stream.push_back(make_beat(i == 0, len));
    end
    for (int c = 0; c < 900; c++) begin
      if (c >= 800) bus.sRx_c1TxAlmFull = 1'b0;
      else if (c % 16 == 0) bus.sRx_c1TxAlmFull = ($urandom_range(0, 2) == 0);
      if (si < stream.size() && $urandom_range(0, 3) != 0) begin drive(stream[si]); si++; end
      else idle();
      tick();
      if (exp_valid) outs++;
      n_cmp++; if (bus.sTx_c1.valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, bus.sTx_c1.valid, exp_valid); end
      n_cmp++; if (bus.sTx_c1.hdr !== exp_hdr) begin n_bad++; $display("FAIL rnd_hdr cyc=%0d got=%h exp=%h", c, bus.sTx_c1.hdr, exp_hdr); end
      if (exp_data_known) begin
        n_cmp++; if (bus.sTx_c1.data !== exp_data) begin n_bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, bus.sTx_c1.data, exp_data); end
      end
      n_cmp++; if (occupancy !== 5'(m_q.size())) begin n_bad++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_q.size()); end
      n_cmp++; if (bus.in_ready !== ((DEPTH - m_q.size()) >= MARGIN)) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", c, bus.in_ready, (DEPTH - m_q.size()) >= MARGIN); end
      n_cmp++; if (drop_cnt !== m_drops) begin n_bad++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", c, drop_cnt, m_drops); end
      n_cmp++; if (error !== m_err) begin n_bad++; $display("FAIL rnd_error cyc=%0d got=%0b exp=%0b", c, error, m_err); end
    end
    $display("test_random: pushed=%0d emitted=%0d drops=%0d", si, outs, m_drops);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_c1 = '0;
    bus.sRx_c1TxAlmFull = 1'b0;
    test_reset();
    test_single();
    test_burst4();
    test_almfull();
    test_overflow();
    test_sop_error();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
